// File: rtl/conv_row_sequencer.sv
// Row sequencer for the type2 streaming-convolution datapath: loads the kernel,
// builds the sliding pixel window and realigns returned results with valid/last.
module conv_row_sequencer #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int IMG_NB    = 3,
    parameter int LEN_WIDTH = 16,
    parameter int LATENCY   = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic [LEN_WIDTH-1:0]            cfg_len,
    input  logic [KER_WIDTH-1:0]            ker_data,
    input  logic                            ker_val,
    output logic                            ker_rdy,
    input  logic [IMG_WIDTH-1:0]            pix_data,
    input  logic                            pix_val,
    output logic                            pix_rdy,
    output logic [KER_WIDTH*IMG_NB-1:0]     dp_ker,
    output logic [IMG_WIDTH*IMG_NB-1:0]     dp_img,
    output logic                            dp_val,
    input  logic [IMG_WIDTH+KER_WIDTH:0]    dp_result,
    output logic [IMG_WIDTH+KER_WIDTH:0]    out_data,
    output logic                            out_val,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    // state    | meaning
    // IDLE     | waiting for cfg_start, row length latched on start
    // LOAD_KER | accepting IMG_NB coefficients, tap 0 first
    // STREAM   | accepting pixels, shifting window, issuing dp_val
    // FLUSH    | waiting for the valid pipe and out_val to drain, then done
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_KER = 2'd1,
        STREAM   = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] NB_LEN  = LEN_WIDTH'(IMG_NB);
    localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

    state_t                                 state_q;
    logic [LEN_WIDTH-1:0]                   len_q;
    logic [LEN_WIDTH-1:0]                   k_cnt_q;
    logic [LEN_WIDTH-1:0]                   p_cnt_q;
    logic [LEN_WIDTH-1:0]                   k_cnt_d;
    logic [LEN_WIDTH-1:0]                   p_cnt_d;
    logic [IMG_NB-1:0][KER_WIDTH-1:0]       ker_q;
    logic [IMG_NB-1:0][IMG_WIDTH-1:0]       win_q;
    logic                                   dp_val_q;
    logic                                   dp_last_q;
    logic                                   err_q;
    logic                                   done_q;

    logic [LATENCY-1:0]                     vpipe_q;
    logic [LATENCY-1:0]                     lpipe_q;
    logic [IMG_WIDTH+KER_WIDTH:0]           out_data_q;
    logic                                   out_val_q;
    logic                                   out_last_q;
    logic                                   pipe_empty;

    assign k_cnt_d    = k_cnt_q + ONE_LEN;
    assign p_cnt_d    = p_cnt_q + ONE_LEN;
    assign pipe_empty = !dp_val_q && (vpipe_q == '0) && !out_val_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            k_cnt_q   <= '0;
            p_cnt_q   <= '0;
            ker_q     <= '0;
            win_q     <= '0;
            dp_val_q  <= 1'b0;
            dp_last_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dp_val_q  <= 1'b0;
            dp_last_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        len_q   <= cfg_len;
                        k_cnt_q <= '0;
                        p_cnt_q <= '0;
                        win_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= LOAD_KER;
                    end
                end
                LOAD_KER: begin
                    if (ker_val) begin
                        for (int i = 0; i < IMG_NB; i++) begin
                            if (k_cnt_q == LEN_WIDTH'(i)) ker_q[i] <= ker_data;
                        end
                        k_cnt_q <= k_cnt_d;
                        if (k_cnt_d == NB_LEN) begin
                            // a row shorter than the kernel yields no windows at all
                            if (len_q < NB_LEN) begin
                                err_q   <= 1'b1;
                                state_q <= FLUSH;
                            end else begin
                                state_q <= STREAM;
                            end
                        end
                    end
                end
                STREAM: begin
                    if (pix_val) begin
                        for (int i = 0; i < IMG_NB - 1; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[IMG_NB-1] <= pix_data;
                        p_cnt_q         <= p_cnt_d;
                        if (p_cnt_d >= NB_LEN) begin
                            dp_val_q  <= 1'b1;
                            dp_last_q <= (p_cnt_d == len_q);
                        end
                        if (p_cnt_d == len_q) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pipe_empty) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // dp_val/last delayed to line up with dp_result, then captured together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe_q    <= '0;
            lpipe_q    <= '0;
            out_data_q <= '0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            vpipe_q[0] <= dp_val_q;
            lpipe_q[0] <= dp_last_q;
            for (int i = 1; i < LATENCY; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                lpipe_q[i] <= lpipe_q[i-1];
            end
            out_val_q  <= vpipe_q[LATENCY-1];
            out_last_q <= vpipe_q[LATENCY-1] & lpipe_q[LATENCY-1];
            if (vpipe_q[LATENCY-1]) out_data_q <= dp_result;
        end
    end

    assign ker_rdy  = (state_q == LOAD_KER);
    assign pix_rdy  = (state_q == STREAM);
    assign busy     = (state_q != IDLE);
    assign dp_ker   = ker_q;
    assign dp_img   = win_q;
    assign dp_val   = dp_val_q;
    assign out_data = out_data_q;
    assign out_val  = out_val_q;
    assign out_last = out_last_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench for conv_row_sequencer with a behavioural dot-product datapath
// of latency 7 closing the loop from dp_img/dp_ker to dp_result.
module tb_conv_row_sequencer;

    localparam int IW  = 16;
    localparam int KW  = 8;
    localparam int NB  = 3;
    localparam int LW  = 16;
    localparam int LAT = 7;
    localparam int RW  = IW + KW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [LW-1:0]     cfg_len;
    logic [KW-1:0]     ker_data;
    logic              ker_val;
    logic              ker_rdy;
    logic [IW-1:0]     pix_data;
    logic              pix_val;
    logic              pix_rdy;
    logic [KW*NB-1:0]  dp_ker;
    logic [IW*NB-1:0]  dp_img;
    logic              dp_val;
    logic [RW-1:0]     dp_result;
    logic [RW-1:0]     out_data;
    logic              out_val;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    conv_row_sequencer #(
        .IMG_WIDTH(IW), .KER_WIDTH(KW), .IMG_NB(NB), .LEN_WIDTH(LW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .ker_data(ker_data), .ker_val(ker_val), .ker_rdy(ker_rdy),
        .pix_data(pix_data), .pix_val(pix_val), .pix_rdy(pix_rdy),
        .dp_ker(dp_ker), .dp_img(dp_img), .dp_val(dp_val), .dp_result(dp_result),
        .out_data(out_data), .out_val(out_val), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    // behavioural datapath: dot product of current window and kernel, LAT cycles later
    logic signed [RW-1:0] dot;
    logic signed [RW-1:0] dp_pipe [LAT];

    always_comb begin
        dot = '0;
        for (int i = 0; i < NB; i++) begin
            dot = dot + RW'($signed(dp_img[i*IW +: IW])) * RW'($signed(dp_ker[i*KW +: KW]));
        end
    end

    always @(posedge clk) begin
        dp_pipe[0] <= dot;
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_result = dp_pipe[LAT-1];

    // monitor, sampling on the falling edge
    int            cyc = 0;
    int            dpv_cnt;
    int            done_cnt;
    int            done_cyc;
    logic          done_err;
    logic [RW-1:0] got_data [$];
    logic          got_last [$];
    int            got_cyc  [$];

    always @(negedge clk) begin
        cyc++;
        if (dp_val) dpv_cnt++;
        if (out_val) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string                    name;
        logic [NB-1:0][KW-1:0]    ker;
        int                       len;
        logic [5:0][IW-1:0]       pix;
        int                       gap_at;
        int                       gap_len;
        int                       ker_gap;
        int                       n_exp;
        logic [3:0][RW-1:0]       exp;
        int                       gap_idx;
        bit                       exp_err;
        bit                       restart;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [NB*KW-1:0] k, input int len,
                                input logic [6*IW-1:0] p, input int ga, input int gl,
                                input int kg, input int n, input logic [4*RW-1:0] e,
                                input int gi, input bit er, input bit rs);
        vec_t v;
        v.name = nm;  v.ker = k;      v.len = len;  v.pix = p;
        v.gap_at = ga; v.gap_len = gl; v.ker_gap = kg; v.n_exp = n;
        v.exp = e;    v.gap_idx = gi; v.exp_err = er; v.restart = rs;
        return v;
    endfunction

    task automatic start_row(input int len);
        cfg_start = 1'b1;
        cfg_len   = LW'(len);
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic load_ker(input logic [NB-1:0][KW-1:0] k, input int gap,
                            output bit early, output bit tout);
        int t;
        early = 1'b0;
        tout  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            for (int g = 0; g < gap; g++) begin
                if (pix_rdy) early = 1'b1;
                @(posedge clk); #1;
            end
            ker_data = k[i];
            ker_val  = 1'b1;
            t = 0;
            while (!ker_rdy && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 100) tout = 1'b1;
            if (pix_rdy) early = 1'b1;
            @(posedge clk); #1;
            ker_val = 1'b0;
        end
    endtask

    task automatic feed_pix(input logic [IW-1:0] d, inout bit tout);
        int t;
        pix_data = d;
        pix_val  = 1'b1;
        t = 0;
        while (!pix_rdy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) tout = 1'b1;
        @(posedge clk); #1;
        pix_val = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit early, tout;
        int t, n;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        dpv_cnt = 0; done_cnt = 0; done_cyc = 0; done_err = 1'b0;
        start_row(v.len);
        if (v.restart) start_row(5);
        load_ker(v.ker, v.ker_gap, early, tout);
        check({v.name, ".pix_rdy_before_kernel"}, longint'(early), 0);
        if (!v.exp_err) begin
            for (int p = 0; p < v.len; p++) begin
                if (p == v.gap_at && v.gap_len > 0) repeat (v.gap_len) @(posedge clk);
                #0;
                feed_pix(v.pix[p], tout);
            end
        end
        t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) tout = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({v.name, ".timeout"}, longint'(tout), 0);
        check({v.name, ".done_pulses"}, done_cnt, 1);
        check({v.name, ".err_at_done"}, longint'(done_err), longint'(v.exp_err));
        check({v.name, ".err_held"}, longint'(err), longint'(v.exp_err));
        check({v.name, ".busy_after"}, longint'(busy), 0);
        check({v.name, ".dp_val_count"}, dpv_cnt, v.n_exp);
        check({v.name, ".n_results"}, got_data.size(), v.n_exp);
        n = (got_data.size() < v.n_exp) ? got_data.size() : v.n_exp;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.data%0d", v.name, i),
                  longint'($signed(got_data[i])), longint'($signed(v.exp[i])));
            check($sformatf("%s.last%0d", v.name, i),
                  longint'(got_last[i]), longint'(i == v.n_exp - 1));
            if (i > 0)
                check($sformatf("%s.gap%0d", v.name, i),
                      longint'(got_cyc[i] - got_cyc[i-1] > 1), longint'(i == v.gap_idx));
        end
        if (v.n_exp > 0 && n == v.n_exp)
            check({v.name, ".done_after_drain"}, done_cyc - got_cyc[n-1], 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},     longint'(busy), 0);
        check({tag, ".ker_rdy"},  longint'(ker_rdy), 0);
        check({tag, ".pix_rdy"},  longint'(pix_rdy), 0);
        check({tag, ".dp_val"},   longint'(dp_val), 0);
        check({tag, ".dp_ker"},   longint'(dp_ker), 0);
        check({tag, ".dp_img"},   longint'(dp_img), 0);
        check({tag, ".out_val"},  longint'(out_val), 0);
        check({tag, ".out_last"}, longint'(out_last), 0);
        check({tag, ".out_data"}, longint'(out_data), 0);
        check({tag, ".done"},     longint'(done), 0);
        check({tag, ".err"},      longint'(err), 0);
    endtask

    vec_t vecs [7];

    initial begin
        bit early, tout;
        vecs[0] = mk("k123_len5", {8'd3, 8'd2, 8'd1}, 5,
                     {16'd0, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 99, 0, 0, 3,
                     {25'd0, 25'd26, 25'd20, 25'd14}, 0, 1'b0, 1'b0);
        vecs[1] = mk("pix_gap20", {8'd3, 8'd2, 8'd1}, 5,
                     {16'd0, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3, 20, 0, 3,
                     {25'd0, 25'd26, 25'd20, 25'd14}, 1, 1'b0, 1'b0);
        vecs[2] = mk("len3_neg", {8'd3, 8'd2, 8'd1}, 3,
                     {16'd0, 16'd0, 16'd0, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 99, 0, 0, 1,
                     {25'd0, 25'd0, 25'd0, 25'h1FFFFF2}, 0, 1'b0, 1'b0);
        vecs[3] = mk("len2_err", {8'd3, 8'd2, 8'd1}, 2,
                     '0, 99, 0, 0, 0, '0, 0, 1'b1, 1'b1);
        vecs[4] = mk("ker_gap4", {8'd3, 8'd2, 8'd1}, 5,
                     {16'd0, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 99, 0, 4, 3,
                     {25'd0, 25'd26, 25'd20, 25'd14}, 0, 1'b0, 1'b0);
        vecs[5] = mk("mixed_len4", {8'd2, 8'd0, 8'hFF}, 4,
                     {16'd0, 16'd0, 16'hFFD8, 16'd30, 16'hFFEC, 16'd10}, 99, 0, 0, 2,
                     {25'd0, 25'd0, 25'h1FFFFC4, 25'd50}, 0, 1'b0, 1'b0);
        vecs[6] = mk("extreme", {8'd1, 8'h80, 8'h7F}, 3,
                     {16'd0, 16'd0, 16'd0, 16'h7FFF, 16'h8000, 16'h7FFF}, 99, 0, 0, 1,
                     {25'd0, 25'd0, 25'd0, 25'd8388480}, 0, 1'b0, 1'b0);

        rst = 1'b0; cfg_start = 1'b0; cfg_len = '0;
        ker_data = '0; ker_val = 1'b0; pix_data = '0; pix_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        @(posedge clk); #1;

        // reset asserted in the middle of a row
        start_row(5);
        load_ker({8'd3, 8'd2, 8'd1}, 0, early, tout);
        tout = 1'b0;
        feed_pix(16'd7, tout);
        feed_pix(16'd9, tout);
        check("midrst.pre_busy", longint'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want < 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule
